// File: rtl/sub_32bit_seq_if.sv
// Valid/ready operand and result bundle for the byte-serial subtractor.
interface sub_32bit_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             neg;
  logic             zero;
  logic             ovf;
  logic             lt;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, neg, zero, ovf, lt
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, neg, zero, ovf, lt
  );
endinterface

// File: rtl/sub_32bit_seq.sv
// Slice-serial two's-complement subtractor: diff = a + ~b + 1, one SLICE-bit
// slice per clock, LSB first, with registered result and compare flags.
module sub_32bit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic            clk,
  input  logic            rst,
  sub_32bit_seq_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("sub_32bit_seq: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bn_r;
  logic             carry_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             neg_r;
  logic             zero_r;
  logic             ovf_r;
  logic             lt_r;

  logic [SLICE-1:0] slice_a_s;
  logic [SLICE-1:0] slice_bn_s;
  logic [SLICE-1:0] slice_sum_s;
  logic             carry_out_s;
  logic [WIDTH-1:0] diff_upd_s;
  logic             ovf_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // One slice of a + ~b + carry, merged into the running result
  always_comb begin
    slice_a_s                           = a_r[int'(idx_r) * SLICE +: SLICE];
    slice_bn_s                          = bn_r[int'(idx_r) * SLICE +: SLICE];
    {carry_out_s, slice_sum_s}          = {1'b0, slice_a_s} + {1'b0, slice_bn_s}
                                          + {{SLICE{1'b0}}, carry_r};
    diff_upd_s                          = diff_r;
    diff_upd_s[int'(idx_r) * SLICE +: SLICE] = slice_sum_s;
    // bn_r holds ~b, so the subtrahend sign is its inverted MSB
    ovf_s = (a_r[WIDTH-1] != ~bn_r[WIDTH-1]) && (diff_upd_s[WIDTH-1] != a_r[WIDTH-1]);
  end

  // Operand capture, slice datapath and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r    <= {IDX_W{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      bn_r     <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      neg_r    <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      lt_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            bn_r    <= ~bus.b;
            carry_r <= 1'b1;
            idx_r   <= {IDX_W{1'b0}};
          end
        end
        CALC: begin
          diff_r  <= diff_upd_s;
          carry_r <= carry_out_s;
          if (idx_r == LAST_IDX) begin
            idx_r    <= {IDX_W{1'b0}};
            borrow_r <= ~carry_out_s;
            neg_r    <= diff_upd_s[WIDTH-1];
            zero_r   <= (diff_upd_s == {WIDTH{1'b0}});
            ovf_r    <= ovf_s;
            lt_r     <= diff_upd_s[WIDTH-1] ^ ovf_s;
          end else begin
            idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.diff      = diff_r;
  assign bus.borrow    = borrow_r;
  assign bus.neg       = neg_r;
  assign bus.zero      = zero_r;
  assign bus.ovf       = ovf_r;
  assign bus.lt        = lt_r;

endmodule

// File: tb/tb_sub_32bit_seq.sv
// Scoreboard bench for sub_32bit_seq: directed corner cases, handshake,
// mid-operation reset and random operand pairs against an a-b reference.
module tb_sub_32bit_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_32bit_seq_if #(.WIDTH(W)) bus();
  sub_32bit_seq #(.WIDTH(W), .SLICE(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [W-1:0] diff;
    logic borrow;
    logic neg;
    logic zero;
    logic ovf;
    logic lt;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    e.diff   = a - b;
    e.borrow = (a < b);
    e.neg    = e.diff[W-1];
    e.zero   = (e.diff == 32'd0);
    e.ovf    = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
    e.lt     = ($signed(a) < $signed(b));
    return e;
  endfunction

  function automatic res_t cur();
    res_t r;
    r.diff   = bus.diff;
    r.borrow = bus.borrow;
    r.neg    = bus.neg;
    r.zero   = bus.zero;
    r.ovf    = bus.ovf;
    r.lt     = bus.lt;
    return r;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb_q.push_back(model(a, b));
    bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic receive(input string name, input int hold, output int lat);
    res_t got, e;
    bit   stable;
    int   n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1; n++;
      bus.a = $urandom; bus.b = $urandom;
    end
    lat = n;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, bus.out_valid, n);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      return;
    end
    got = cur();
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (cur() !== got || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
      end
      n_checks++;
      if (!stable) begin
        n_fail++;
        $display("FAIL %s_hold: result/out_valid/in_ready changed under backpressure, got %h ov=%b ir=%b, required %h ov=1 ir=0",
                 name, cur(), bus.out_valid, bus.in_ready, got);
      end
    end
    e = sb_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s_result: got diff=%h b/n/z/o/l=%b%b%b%b%b, required diff=%h b/n/z/o/l=%b%b%b%b%b",
               name, got.diff, got.borrow, got.neg, got.zero, got.ovf, got.lt,
               e.diff, e.borrow, e.neg, e.zero, e.ovf, e.lt);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+6:0] obs;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus.in_ready, bus.out_valid, cur()};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 37'd0}) begin
      n_fail++;
      $display("FAIL reset_during: got ir/ov/res=%h, required %h", obs, {1'b1, 1'b0, 37'd0});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    obs = {bus.in_ready, bus.out_valid, cur()};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 37'd0}) begin
      n_fail++;
      $display("FAIL reset_after: got ir/ov/res=%h, required %h", obs, {1'b1, 1'b0, 37'd0});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] av[7] = '{32'd5, 32'd3, 32'h80000000, 32'h7FFFFFFF, 32'h01000000, 32'hDEADBEEF, 32'hFFFFFFFF};
    logic [W-1:0] bv[7] = '{32'd3, 32'd5, 32'd1,        32'hFFFFFFFF, 32'd1,        32'hDEADBEEF, 32'h00000000};
    int lat;
    for (int i = 0; i < 7; i++) begin
      send(av[i], bv[i]);
      receive("directed", 0, lat);
      if (i == 0) begin
        n_checks++;
        if (lat != 4) begin
          n_fail++;
          $display("FAIL latency: out_valid after %0d cycles, required 4", lat);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(32'h12345678, 32'h87654321);
    receive("backpressure", 10, lat);
  endtask

  task automatic test_back_to_back();
    int   acc[$];
    int   outs = 0;
    bit   rdy, ovd, ivd;
    res_t got, e;
    logic [W-1:0] av, bv;
    av = $urandom; bv = $urandom;
    bus.a = av; bus.b = bv; bus.out_ready = 1'b1;
    for (int i = 0; i < 60 && outs < 4; i++) begin
      bus.in_valid = (acc.size() < 4);
      ivd = bus.in_valid; rdy = bus.in_ready; ovd = bus.out_valid; got = cur();
      if (ovd) begin
        n_checks++;
        if (rdy) begin
          n_fail++;
          $display("FAIL b2b_done_ready: in_ready=1 in DONE, required 0");
        end
        e = sb_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL b2b_result: got %h, required %h", got, e);
        end
        outs++;
      end
      @(posedge clk); #1;
      if (rdy && ivd) begin
        acc.push_back(cyc);
        sb_q.push_back(model(av, bv));
        av = $urandom; bv = $urandom;
        bus.a = av; bus.b = bv;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_checks++;
    if (outs != 4) begin
      n_fail++;
      $display("FAIL b2b_count: %0d results, required 4", outs);
    end
    for (int k = 1; k < acc.size(); k++) begin
      n_checks++;
      if (acc[k] - acc[k-1] != 6) begin
        n_fail++;
        $display("FAIL b2b_ii: interval %0d cycles, required 6", acc[k] - acc[k-1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    res_t e;
    logic [W+6:0] obs;
    bit   seen = 1'b0;
    int   lat;
    send(32'h12345678, 32'h00000001);
    e = sb_q.pop_front();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    obs = {bus.in_ready, bus.out_valid, cur()};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 37'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: got ir/ov/res=%h, required %h", obs, {1'b1, 1'b0, 37'd0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL mid_reset_valid: out_valid=1 after abort, required 0");
    end
    send(32'd9, 32'd4);
    receive("after_reset", 0, lat);
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 2000; i++) begin
      send($urandom, ($urandom_range(0, 7) == 0) ? bus.a : $urandom);
      receive("random", $urandom_range(0, 2), lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
